// File: rtl/steer_out_buffer.sv
// steer_out_buffer: packs four steer-module bytes into 32-bit words, buffers them in a
// first-word-fall-through FIFO and frames them into FRAME_WORDS-word frames.
module steer_out_buffer #(
  parameter int DEPTH       = 8,
  parameter int FRAME_WORDS = 512
) (
  input  logic                     CLK,
  input  logic                     rst,
  input  logic                     in_valid,
  input  logic [7:0]               in_b0,
  input  logic [7:0]               in_b1,
  input  logic [7:0]               in_b2,
  input  logic [7:0]               in_b3,
  input  logic                     out_ready,
  output logic                     out_valid,
  output logic [31:0]              out_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty,
  output logic                     overflow,
  output logic                     frame_done
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(FRAME_WORDS) + 1;
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);
  localparam logic [CW-1:0] LAST_WORD = CW'(FRAME_WORDS);

  typedef enum logic [1:0] {IDLE, FILL, DRAIN, DONE} state_t;

  state_t        state_q, state_d;
  logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [AW:0]   count_q, count_d;
  logic [CW-1:0] wc_q, wc_d;
  logic          ovf_q, ovf_d;
  logic [31:0]   mem_q [DEPTH];
  logic          push, pop;

  assign empty     = count_q == '0;
  assign full      = count_q == FULL_CNT;
  assign out_valid = !empty;
  assign out_data  = empty ? '0 : mem_q[rd_q];
  assign count     = count_q;
  assign overflow  = ovf_q;
  assign push      = in_valid && (state_q == IDLE || state_q == FILL) && !full;
  assign pop       = out_valid && out_ready;

  always_comb begin
    wr_d    = wr_q + AW'(push);
    rd_d    = rd_q + AW'(pop);
    count_d = count_q + (AW+1)'(push) - (AW+1)'(pop);
    ovf_d   = ovf_q || (in_valid && !push);
  end

  always_ff @(posedge CLK) begin
    if (!rst) begin
      state_q <= IDLE;
      wr_q    <= '0;
      rd_q    <= '0;
      count_q <= '0;
      wc_q    <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      count_q <= count_d;
      wc_q    <= wc_d;
      ovf_q   <= ovf_d;
    end
  end

  // Storage is deliberately left uncleared by reset; occupancy alone defines validity.
  always_ff @(posedge CLK) begin
    if (push) mem_q[wr_q] <= {in_b3, in_b2, in_b1, in_b0};
  end

  // DRAIN exits on the cycle its final pop empties the FIFO, so DONE follows that pop directly.
  always_comb begin
    state_d = state_q;
    wc_d    = wc_q;
    case (state_q)
      IDLE, FILL: begin
        if (push) begin
          wc_d    = wc_q + CW'(1);
          state_d = (wc_q + CW'(1) == LAST_WORD) ? DRAIN : FILL;
        end
      end
      DRAIN: state_d = (count_d == '0) ? DONE : DRAIN;
      DONE: begin
        state_d = IDLE;
        wc_d    = '0;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    frame_done = state_q == DONE;
  end
endmodule

// File: tb/tb_steer_out_buffer.sv
// tb_steer_out_buffer: randomized and directed stimulus checked every cycle against a
// queue-based frame/FIFO reference model.
module tb_steer_out_buffer;
  localparam int DEPTH = 8;
  localparam int FW    = 512;

  logic        CLK = 1'b0;
  logic        rst = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic [7:0]  in_b0 = '0, in_b1 = '0, in_b2 = '0, in_b3 = '0;
  logic        out_valid;
  logic [31:0] out_data;
  logic [3:0]  count;
  logic        full, empty, overflow, frame_done;

  steer_out_buffer #(.DEPTH(DEPTH), .FRAME_WORDS(FW)) dut (
    .CLK(CLK), .rst(rst), .in_valid(in_valid),
    .in_b0(in_b0), .in_b1(in_b1), .in_b2(in_b2), .in_b3(in_b3),
    .out_ready(out_ready), .out_valid(out_valid), .out_data(out_data),
    .count(count), .full(full), .empty(empty), .overflow(overflow),
    .frame_done(frame_done)
  );

  always #5 CLK = ~CLK;

  int          n_chk = 0, n_fail = 0;
  logic [31:0] q[$];
  int          phase = 0;
  int          wcnt = 0;
  bit          m_ovf = 0, live = 0, just_reset = 0;
  int          fd_seen = 0, max_cnt = 0;

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic compare();
    check("out_valid", out_valid, q.size() != 0);
    if (q.size() != 0) check("out_data", out_data, q[0]);
    if (just_reset) check("rst_out_data", out_data, 0);
    check("count", count, q.size());
    check("full", full, q.size() == DEPTH);
    check("empty", empty, q.size() == 0);
    check("overflow", overflow, m_ovf);
    check("frame_done", frame_done, phase == 3);
    fd_seen += int'(frame_done);
    if (int'(count) > max_cnt) max_cnt = int'(count);
  endtask

  // One clock: compare outputs mid-cycle, drive inputs, then advance the model.
  task automatic cyc(bit r, bit iv, logic [31:0] w, bit rd);
    bit acc;
    @(negedge CLK);
    if (live) compare();
    rst = r;
    in_valid = iv;
    {in_b3, in_b2, in_b1, in_b0} = w;
    out_ready = rd;
    if (!r) begin
      q.delete();
      phase = 0; wcnt = 0; m_ovf = 0; live = 1; just_reset = 1;
    end else if (live) begin
      just_reset = 0;
      acc = iv && phase < 2 && q.size() < DEPTH;
      if (rd && q.size() > 0) void'(q.pop_front());
      if (acc) q.push_back(w);
      if (iv && !acc) m_ovf = 1;
      if (phase == 3) begin
        phase = 0; wcnt = 0;
      end else if (phase == 2) begin
        if (q.size() == 0) phase = 3;
      end else if (acc) begin
        wcnt++;
        phase = (wcnt == FW) ? 2 : 1;
      end
    end
  endtask

  initial begin
    cyc(0, 1, 32'hffff_ffff, 1);
    cyc(0, 0, 0, 0);
    // single word
    cyc(1, 1, 32'h4433_2211, 0);
    cyc(1, 0, 0, 0);
    check("single_data", out_data, 32'h4433_2211);
    check("single_count", count, 1);
    // fill to full and overflow, then pop in order
    cyc(0, 0, 0, 0);
    for (int i = 0; i < 9; i++) cyc(1, 1, i + 1, 0);
    cyc(1, 0, 0, 0);
    check("fill_full", full, 1);
    check("fill_ovf", overflow, 1);
    for (int i = 0; i < 8; i++) begin
      cyc(1, 0, 0, 1);
      check("fill_pop", out_data, i + 1);
    end
    // full with simultaneous push and pop
    cyc(0, 0, 0, 0);
    for (int i = 0; i < 8; i++) cyc(1, 1, 32'h100 + i, 0);
    cyc(1, 1, 32'hdead_beef, 1);
    cyc(1, 0, 0, 0);
    check("fullpp_count", count, 7);
    check("fullpp_ovf", overflow, 1);
    // streaming one whole frame
    cyc(0, 0, 0, 0);
    fd_seen = 0; max_cnt = 0;
    for (int i = 0; i < FW; i++) cyc(1, 1, $urandom, 1);
    for (int i = 0; i < 4; i++) cyc(1, 0, 0, 1);
    check("stream_fd", fd_seen, 1);
    check("stream_max_cnt", max_cnt <= 1, 1);
    check("stream_ovf", overflow, 0);
    // reset mid-frame
    cyc(0, 0, 0, 0);
    for (int i = 0; i < 3; i++) cyc(1, 1, 32'h500 + i, 0);
    cyc(0, 0, 0, 0);
    cyc(1, 0, 0, 0);
    check("midrst_count", count, 0);
    check("midrst_empty", empty, 1);
    check("midrst_valid", out_valid, 0);
    // randomized traffic across several frames
    fd_seen = 0;
    for (int i = 0; i < 3000; i++)
      cyc($urandom_range(0, 799) != 0, $urandom_range(0, 9) < 7, $urandom, $urandom_range(0, 1) == 1);
    cyc(1, 0, 0, 0);
    check("random_frames_seen", fd_seen > 0, 1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/steer_out_buffer.md
STEER_OUT_BUFFER -- requirements
Module: steer_out_buffer

Interface
REQ-001 The block SHALL have parameter DEPTH, default 8, FIFO depth in 32-bit words (power of two, >= 2).
REQ-002 The block SHALL have parameter FRAME_WORDS, default 512, words per frame (matches the 9-bit BRAM port-B read span).
REQ-003 The block SHALL have port CLK, input, 1, the single clock; all logic is on its rising edge.
REQ-004 The block SHALL have port rst, input, 1, reset; synchronous, active-low (0 = reset).
REQ-005 The block SHALL have port in_valid, input, 1, steer-module bytes valid this cycle (driven from SM_EN qualification).
REQ-006 The block SHALL have ports in_b0, in_b1, in_b2, in_b3, each input, 8, steer-module Out1..Out4 respectively.
REQ-007 The block SHALL have port out_ready, input, 1, consumer accepts the head word.
REQ-008 The block SHALL have port out_valid, output, 1, the head word is present.
REQ-009 The block SHALL have port out_data, output, 32, the head word.
REQ-010 The block SHALL have port count, output, $clog2(DEPTH)+1, FIFO occupancy 0..DEPTH.
REQ-011 The block SHALL have ports full and empty, each output, 1, meaning count==DEPTH and count==0.
REQ-012 The block SHALL have port overflow, output, 1, sticky flag set on any dropped input.
REQ-013 The block SHALL have port frame_done, output, 1, one-cycle pulse at end of frame.

Function
REQ-014 The packed word SHALL be {in_b3,in_b2,in_b1,in_b0}, with in_b0 at bits [7:0].
REQ-015 The FIFO SHALL be first-word-fall-through: out_valid = !empty, and out_data is the oldest stored word, valid the cycle after it is written.
REQ-016 A push SHALL be accepted when in_valid=1, state is FILL or IDLE, and full=0 at the start of the cycle.
REQ-017 A pop SHALL occur when out_valid=1 and out_ready=1; out_data and out_valid are ignored while out_valid=0.
REQ-018 On a simultaneous accepted push and pop, count SHALL stay unchanged and both pointers SHALL advance.
REQ-019 When full=1, in_valid=1 SHALL drop the input and set overflow, even if a pop occurs in the same cycle.
REQ-020 Read and write pointers SHALL wrap modulo DEPTH; count SHALL never exceed DEPTH or go below 0.
REQ-021 The FSM SHALL have four states: IDLE, FILL, DRAIN, DONE.
REQ-022 In IDLE, the first accepted push SHALL transition to FILL, and word_cnt SHALL become 1.
REQ-023 In FILL, each accepted push SHALL increment the internal word_cnt; the push that makes word_cnt==FRAME_WORDS SHALL transition to DRAIN.
REQ-024 In DRAIN, in_valid=1 SHALL be dropped and SHALL set overflow; when empty=1 (after the final pop), the FSM SHALL transition to DONE.
REQ-025 In DONE, frame_done=1 for exactly one cycle; then the FSM SHALL transition to IDLE with word_cnt=0. overflow is NOT cleared.
REQ-026 If FRAME_WORDS words are accepted and already popped in the same cycle, DRAIN SHALL last one cycle and then enter DONE.
REQ-027 overflow SHALL clear only on reset.

Reset
REQ-028 When rst=0 at a rising CLK edge, the block SHALL reset: state=IDLE, pointers=0, word_cnt=0, count=0, empty=1, full=0, out_valid=0, out_data=0, overflow=0, frame_done=0.
REQ-029 Reset SHALL take priority over any simultaneous push or pop.
REQ-030 A reset mid-frame SHALL discard all stored words; storage contents need not be cleared.
REQ-031 The first push SHALL be accepted on the first edge with rst=1.

Verification
REQ-032 Single word: in_b3..0=0x44,0x33,0x22,0x11 with in_valid for 1 cycle and out_ready=0 -> next cycle out_valid=1, out_data=0x44332211, count=1.
REQ-033 Fill to full: 9 consecutive pushes with DEPTH=8 and out_ready=0 -> full=1 after the 8th; the 9th is dropped, overflow=1; popping returns words 1..8 in order.
REQ-034 Full with simultaneous push and pop: full, in_valid=1, out_ready=1 -> count=7, the push is dropped, overflow=1.
REQ-035 Frame: FRAME_WORDS=4, 4 pushes, then out_ready=1 -> DRAIN until empty; frame_done pulses exactly once, 1 cycle after the last pop; the FSM returns to IDLE; a 5th in_valid during DRAIN sets overflow.
REQ-036 Streaming: in_valid=1 and out_ready=1 every cycle for 512 words -> count stays at or below 1, overflow=0, one frame_done, and the output sequence equals the input sequence.
REQ-037 Reset mid-frame: rst=0 after 3 pushes -> next cycle count=0, empty=1, out_valid=0, state IDLE; the next frame counts from 1.
